scroll_sequencer: RTL and testbench
===================================

// Module: scroll_sequencer
// PURPOSE
//  Mode controller and scroll scheduler for the 8-digit seven-segment scrolling display.
//  Sequences three modes: default message, user programming, user message display.
//  In PROG it captures 16-bit switch words into a nibble message buffer.
//  Outputs the registered 8-digit window (hex nibbles + blank mask) to the downstream
//  digit-mux/seg-decode block. Buttons arrive already debounced as 1-cycle pulses.
// PARAMETERS
//  DEPTH       16            message buffer size in hex digits; multiple of 4, >= 8
//  SCROLL_DIV  50_000_000    clk cycles per scroll step (>= 2)
//  DEF_MSG     32'h1234_5678 default 8-digit message; [31:28] is the first digit
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high
//  prog_pulse   in   1   1-cycle pulse: enter/leave programming mode
//  enter_pulse  in   1   1-cycle pulse: store sw into buffer (PROG only)
//  sw           in   16  4 hex digits; sw[15:12] is the first digit
//  digits       out  32  window nibbles; [31:28] = leftmost digit (an[7]), [3:0] = digit 0
//  blank        out  8   1 = digit i is dark; bit 7 = leftmost digit
//  mode         out  2   0 = DEF_DISP, 1 = PROG, 2 = DISPLAY
//  full         out  1   len == DEPTH
// BEHAVIOUR
//  Reset (async): state DEF_DISP, len = 0, pos = 0, tick counter = 0.
//   Outputs: digits = 0, blank = 8'hFF, mode = 0, full = 0.
//   Buffer contents are not cleared; they are don't-care while len = 0.
//  Scroll sequence: message of L digits (L = 8 in DEF_DISP, L = len in DISPLAY),
//   followed by 8 blank slots, length L+8, circular.
//  Window slot for digit i (i = 7..0): s = (pos + 7 - i) mod (L+8).
//   Shows msg[s] if s < L, else blank (nibble 0, blank bit = 1).
//  Tick counter: 0..SCROLL_DIV-1; tick asserts when count == SCROLL_DIV-1, then count wraps to 0.
//   On tick: pos <= (pos == L+7) ? 0 : pos+1.
//  On every state change: pos <= 0 and counter <= 0.
//  Outputs are registered. digits/blank/mode reflect the state/pos of the previous cycle
//   (1-cycle latency from a state or pos change).
//  FSM:
//   DEF_DISP: prog_pulse -> PROG; len <= 0.
//   PROG: enter_pulse with len < DEPTH writes sw nibbles to buf[len..len+3]; len += 4.
//    enter_pulse when full is ignored; len saturates at DEPTH.
//    prog_pulse -> DISPLAY if the resulting len > 0, else -> DEF_DISP.
//    enter+prog in the same cycle: the write occurs first and counts toward len.
//    Window in PROG: digits[15:0] = live sw; digits[31:24] = len (8-bit, zero-extended
//     or truncated); blank = 8'h30 (digits 5:4 dark). Counter is idle.
//   DISPLAY: scrolls the buffer. prog_pulse -> PROG; len <= 0.
//  enter_pulse outside PROG is ignored.
//  reset mid-scroll or mid-programming: immediate return to reset values.
//  full = (len == DEPTH), registered alongside len.
// TESTING (DEPTH = 16, SCROLL_DIV = 4, DEF_MSG = 32'h1234_5678)
//  1. Release reset, wait 2 clk -> mode = 0, digits = 32'h12345678, blank = 8'h00.
//     After 4 clk -> digits[31:4] = 28'h2345678, blank = 8'h01.
//  2. DEF_DISP run 16 ticks (64 clk) -> window back to 32'h12345678 (wrap at L+8 = 16).
//  3. prog; sw = 16'hABCD, enter; prog -> mode = 2, window = 32'hABCD_xxxx, blank = 8'h0F.
//     After 12 ticks the window repeats.
//  4. prog; 5 enters with sw = 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555
//     -> len = 16, full = 1 after the 4th enter; 5th enter has no effect;
//     DISPLAY starts with digits = 32'h11112222.
//  5. prog, prog (no enter) -> mode = 0. prog; enter and prog in the same cycle
//     -> mode = 2 with len = 4.
//  6. Assert reset during DISPLAY at pos 5 -> next cycle mode = 0, blank = 8'hFF, full = 0,
//     pos = 0.

Source files
------------

// File: rtl/scroll_sequencer.sv
// Mode controller and scroll scheduler for the 8-digit seven-segment display: default message,
// programming from switch words, and scrolling of the programmed nibble buffer.
module scroll_sequencer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned SCROLL_DIV = 50_000_000,
  parameter logic [31:0] DEF_MSG    = 32'h1234_5678
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        prog_pulse,
  input  logic        enter_pulse,
  input  logic [15:0] sw,
  output logic [31:0] digits,
  output logic [7:0]  blank,
  output logic [1:0]  mode,
  output logic        full
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH + 8);
  localparam int unsigned CW = $clog2(SCROLL_DIV);

  typedef enum logic [1:0] {
    StDefDisp = 2'd0,
    StProg    = 2'd1,
    StDisplay = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d, len_w;
  logic [PW-1:0] pos_q, pos_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q;
  logic [31:0]   digits_q, win_digits;
  logic [7:0]    blank_q, win_blank;
  logic [1:0]    mode_q;
  logic [3:0]    buf_q [DEPTH];
  logic          buf_we;
  logic          tick;
  logic          pos_wrap;
  int            msg_len;

  always_comb begin
    msg_len = (state_q == StDisplay) ? int'(len_q) : 8;
  end

  assign tick     = (cnt_q == CW'(SCROLL_DIV - 1));
  assign pos_wrap = (int'(pos_q) == msg_len + 7);

  // Next state; a write in the same cycle as prog_pulse counts toward the exit length.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    buf_we  = 1'b0;
    len_w   = len_q;
    if (state_q == StProg && enter_pulse && len_q < LW'(DEPTH)) begin
      buf_we = 1'b1;
      len_w  = len_q + LW'(4);
    end
    case (state_q)
      StDefDisp: begin
        if (prog_pulse) begin
          state_d = StProg;
          len_d   = '0;
        end
      end
      StProg: begin
        len_d = len_w;
        if (prog_pulse) state_d = (len_w != '0) ? StDisplay : StDefDisp;
      end
      StDisplay: begin
        if (prog_pulse) begin
          state_d = StProg;
          len_d   = '0;
        end
      end
      default: state_d = StDefDisp;
    endcase
    if (state_d != state_q) begin
      pos_d = '0;
      cnt_d = '0;
    end else if (state_q != StProg) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      if (tick) pos_d = pos_wrap ? '0 : pos_q + PW'(1);
    end
  end

  // Window: digit i shows slot (pos + 7 - i) mod (L + 8); slots >= L are dark.
  always_comb begin
    int slot;
    slot       = 0;
    win_digits = '0;
    win_blank  = '1;
    case (state_q)
      StProg: begin
        win_digits[15:0]  = sw;
        win_digits[31:24] = 8'(len_q);
        win_blank         = 8'h30;
      end
      default: begin
        for (int i = 0; i < 8; i++) begin
          slot = int'(pos_q) + 7 - i;
          if (slot >= msg_len + 8) slot = slot - (msg_len + 8);
          if (slot < msg_len) begin
            win_blank[i] = 1'b0;
            if (state_q == StDefDisp) begin
              for (int j = 0; j < 8; j++) begin
                if (slot == j) win_digits[4*i +: 4] = DEF_MSG[4*(7-j) +: 4];
              end
            end else begin
              for (int j = 0; j < int'(DEPTH); j++) begin
                if (slot == j) win_digits[4*i +: 4] = buf_q[j];
              end
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StDefDisp;
      len_q    <= '0;
      pos_q    <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      digits_q <= '0;
      blank_q  <= 8'hFF;
      mode_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      pos_q    <= pos_d;
      cnt_q    <= cnt_d;
      full_q   <= (len_d == LW'(DEPTH));
      digits_q <= win_digits;
      blank_q  <= win_blank;
      mode_q   <= state_q;
    end
  end

  // Buffer is deliberately not reset; contents are ignored while len is zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (buf_we && int'(len_q) == (i - i % 4)) buf_q[i] <= sw[4*(3 - i % 4) +: 4];
    end
  end

  assign digits = digits_q;
  assign blank  = blank_q;
  assign mode   = mode_q;
  assign full   = full_q;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Scoreboard bench for scroll_sequencer: the driver queues hand-computed windows, a monitor
// pops and compares them on the falling edge.
module tb_scroll_sequencer;

  logic        clk;
  logic        reset;
  logic        prog_pulse;
  logic        enter_pulse;
  logic [15:0] sw;
  logic [31:0] digits;
  logic [7:0]  blank;
  logic [1:0]  mode;
  logic        full;

  typedef struct {
    string       name;
    logic [31:0] d;
    logic [7:0]  b;
    logic [1:0]  m;
    logic        f;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests;
  int   n_failed;
  bit   drv_done;

  scroll_sequencer #(
    .DEPTH     (16),
    .SCROLL_DIV(4),
    .DEF_MSG   (32'h1234_5678)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .prog_pulse (prog_pulse),
    .enter_pulse(enter_pulse),
    .sw         (sw),
    .digits     (digits),
    .blank      (blank),
    .mode       (mode),
    .full       (full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [31:0] d, input logic [7:0] b,
                            input logic [1:0] m, input logic f);
    exp_t e;
    e.name = nm;
    e.d    = d;
    e.b    = b;
    e.m    = m;
    e.f    = f;
    exp_q.push_back(e);
  endtask

  // Monitor: the outputs are registered, so the falling edge is a stable sample point.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      if (digits !== e.d || blank !== e.b || mode !== e.m || full !== e.f) begin
        n_failed++;
        $display("FAIL %s: got digits=%h blank=%h mode=%0d full=%b, want digits=%h blank=%h mode=%0d full=%b",
                 e.name, digits, blank, mode, full, e.d, e.b, e.m, e.f);
      end
    end
  end

  initial begin
    logic [15:0] vals [5];
    vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    n_tests = 0;
    n_failed = 0;
    drv_done = 1'b0;
    reset = 1'b0;
    prog_pulse = 1'b0;
    enter_pulse = 1'b0;
    sw = 16'h0000;
    #2 reset = 1'b1;
    adv(2);
    expect_out("reset_state", 32'h0, 8'hFF, 2'd0, 1'b0);
    reset = 1'b0;

    // Default message scroll
    adv(2);  expect_out("def_pos0", 32'h12345678, 8'h00, 2'd0, 1'b0);
    adv(2);  expect_out("def_pos0_hold", 32'h12345678, 8'h00, 2'd0, 1'b0);
    adv(1);  expect_out("def_pos1", 32'h23456780, 8'h01, 2'd0, 1'b0);
    adv(28); expect_out("def_pos8_all_dark", 32'h0, 8'hFF, 2'd0, 1'b0);
    adv(31); expect_out("def_pos15", 32'h01234567, 8'h80, 2'd0, 1'b0);
    adv(1);  expect_out("def_wrap", 32'h12345678, 8'h00, 2'd0, 1'b0);

    // One-word program
    prog_pulse = 1'b1; adv(1);
    prog_pulse = 1'b0; sw = 16'hABCD; adv(1);
    expect_out("prog_len0", 32'h0000ABCD, 8'h30, 2'd1, 1'b0);
    enter_pulse = 1'b1; adv(1);
    enter_pulse = 1'b0; adv(1);
    expect_out("prog_len4", 32'h0400ABCD, 8'h30, 2'd1, 1'b0);
    prog_pulse = 1'b1; adv(1);
    prog_pulse = 1'b0; adv(1);
    expect_out("disp4_pos0", 32'hABCD0000, 8'h0F, 2'd2, 1'b0);
    adv(44); expect_out("disp4_pos11", 32'h0ABCD000, 8'h87, 2'd2, 1'b0);
    adv(4);  expect_out("disp4_wrap", 32'hABCD0000, 8'h0F, 2'd2, 1'b0);

    // Fill to DEPTH, fifth enter ignored
    prog_pulse = 1'b1; adv(1);
    prog_pulse = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sw = vals[k];
      enter_pulse = 1'b1;
      adv(1);
      if (k == 3) expect_out("full_after_4th", 32'h0C004444, 8'h30, 2'd1, 1'b1);
      if (k == 4) expect_out("len16_5th", 32'h10005555, 8'h30, 2'd1, 1'b1);
    end
    enter_pulse = 1'b0; adv(1);
    expect_out("len_saturated", 32'h10005555, 8'h30, 2'd1, 1'b1);
    prog_pulse = 1'b1; adv(1);
    prog_pulse = 1'b0; adv(1);
    expect_out("disp16_pos0", 32'h11112222, 8'h00, 2'd2, 1'b1);
    adv(32); expect_out("disp16_pos8", 32'h33334444, 8'h00, 2'd2, 1'b1);

    // Empty program returns to default; enter+prog in one cycle
    prog_pulse = 1'b1; adv(1);
    prog_pulse = 1'b0; adv(1);
    expect_out("reprog_len0", 32'h00005555, 8'h30, 2'd1, 1'b0);
    prog_pulse = 1'b1; adv(1);
    prog_pulse = 1'b0; adv(1);
    expect_out("empty_to_def", 32'h12345678, 8'h00, 2'd0, 1'b0);
    sw = 16'h9876; prog_pulse = 1'b1; enter_pulse = 1'b1; adv(1);
    prog_pulse = 1'b0; enter_pulse = 1'b0; adv(1);
    expect_out("enter_in_def_ignored", 32'h00009876, 8'h30, 2'd1, 1'b0);
    prog_pulse = 1'b1; enter_pulse = 1'b1; adv(1);
    prog_pulse = 1'b0; enter_pulse = 1'b0; adv(1);
    expect_out("enter_prog_same", 32'h98760000, 8'h0F, 2'd2, 1'b0);

    // Reset mid-scroll
    adv(20); expect_out("disp4_pos5", 32'h00000009, 8'hFE, 2'd2, 1'b0);
    adv(1);
    reset = 1'b1;
    expect_out("async_reset", 32'h0, 8'hFF, 2'd0, 1'b0);
    adv(1);
    reset = 1'b0;
    adv(1);  expect_out("post_reset_pos0", 32'h12345678, 8'h00, 2'd0, 1'b0);
    adv(4);  expect_out("post_reset_pos1", 32'h23456780, 8'h01, 2'd0, 1'b0);

    adv(3);
    drv_done = 1'b1;
    if (exp_q.size() != 0) begin
      n_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

  initial begin
    #100000;
    if (!drv_done) begin
      $display("FAIL watchdog: driver did not complete, got timeout, want completion");
      $fatal(1, "timeout");
    end
  end

endmodule
